// File: rtl/pt_pkg.sv
// Shared phase/frequency codes, FSM state type and default count table for phase_timer.
// The default table holds production cycle counts; unmapped {phase, clk_freq} slots hold 1.
package pt_pkg;

    localparam logic [2:0] PH_IDLE  = 3'b000;
    localparam logic [2:0] PH_FILL  = 3'b001;
    localparam logic [2:0] PH_WASH  = 3'b011;
    localparam logic [2:0] PH_RINSE = 3'b111;
    localparam logic [2:0] PH_SPIN  = 3'b110;

    localparam logic [1:0] F_1MHZ = 2'b00;
    localparam logic [1:0] F_2MHZ = 2'b01;
    localparam logic [1:0] F_4MHZ = 2'b10;
    localparam logic [1:0] F_8MHZ = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pt_state_e;

    localparam int PT_DEF_CNT_W   = 32;
    localparam int PT_DEF_ENTRIES = 32;

    // Seconds of real time per phase multiplied by the clock rate in MHz.
    function automatic logic [PT_DEF_CNT_W-1:0] pt_production_count(
        input logic [2:0] ph,
        input logic [1:0] freq
    );
        longint unsigned seconds;
        longint unsigned mhz;
        seconds = 0;
        mhz     = 1;
        case (ph)
            PH_FILL, PH_RINSE: seconds = 120;
            PH_WASH:           seconds = 300;
            PH_SPIN:           seconds = 60;
            PH_IDLE:           seconds = 0;
            default:           seconds = 0;
        endcase
        case (freq)
            F_1MHZ: mhz = 1;
            F_2MHZ: mhz = 2;
            F_4MHZ: mhz = 4;
            F_8MHZ: mhz = 8;
        endcase
        if (seconds == 0) begin
            return PT_DEF_CNT_W'(1);
        end
        return PT_DEF_CNT_W'(seconds * mhz * 64'd1_000_000);
    endfunction

    function automatic logic [PT_DEF_ENTRIES*PT_DEF_CNT_W-1:0] pt_build_default_table();
        logic [PT_DEF_ENTRIES*PT_DEF_CNT_W-1:0] tbl;
        tbl = '0;
        for (int i = 0; i < PT_DEF_ENTRIES; i++) begin
            tbl[i*PT_DEF_CNT_W +: PT_DEF_CNT_W] = pt_production_count(3'(i >> 2), 2'(i));
        end
        return tbl;
    endfunction

    localparam logic [PT_DEF_ENTRIES*PT_DEF_CNT_W-1:0] PT_DEFAULT_TABLE = pt_build_default_table();

endpackage

// File: rtl/phase_count_lut.sv
// Combinational count lookup indexed by {phase, clk_freq}.
// Zero entries read back as 1 so a started countdown always terminates.
module phase_count_lut
    import pt_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PHASE_W = 3,
    parameter int FREQ_W  = 2,
    parameter logic [(2**(PHASE_W+FREQ_W))*CNT_W-1:0] COUNT_TABLE = PT_DEFAULT_TABLE
) (
    input  logic [PHASE_W-1:0] phase,
    input  logic [FREQ_W-1:0]  clk_freq,
    output logic [CNT_W-1:0]   count
);

    localparam int IDX_W = PHASE_W + FREQ_W;

    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] entry;

    assign index = {phase, clk_freq};
    assign entry = COUNT_TABLE[int'(index) * CNT_W +: CNT_W];
    assign count = (entry == '0) ? CNT_W'(1) : entry;

endmodule

// File: rtl/phase_timer.sv
// Phase countdown timer: loads a count by {phase, clk_freq} on start, counts it down, pulses done.
// Define PHASE_TIMER_PRESCALE_EN to decrement once every PRESCALE clocks instead of every clock.
module phase_timer
    import pt_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PHASE_W  = 3,
    parameter int FREQ_W   = 2,
    parameter logic [(2**(PHASE_W+FREQ_W))*CNT_W-1:0] COUNT_TABLE = PT_DEFAULT_TABLE,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [PHASE_W-1:0] phase,
    input  logic [FREQ_W-1:0]  clk_freq,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   remaining
);

    pt_state_e          state;
    pt_state_e          next_state;
    logic [PHASE_W-1:0] phase_q;
    logic [FREQ_W-1:0]  freq_q;
    logic [PHASE_W-1:0] lut_phase;
    logic [FREQ_W-1:0]  lut_freq;
    logic [CNT_W-1:0]   load_count;
    logic               tick;
    logic               step;
    logic               expire;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("phase_timer: PRESCALE must be at least 1");
    end

    // The LUT follows the live inputs on start and the latched job otherwise.
    assign lut_phase = start ? phase : phase_q;
    assign lut_freq  = start ? clk_freq : freq_q;

    phase_count_lut #(
        .CNT_W      (CNT_W),
        .PHASE_W    (PHASE_W),
        .FREQ_W     (FREQ_W),
        .COUNT_TABLE(COUNT_TABLE)
    ) u_lut (
        .phase   (lut_phase),
        .clk_freq(lut_freq),
        .count   (load_count)
    );

`ifdef PHASE_TIMER_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] prescaler;

    assign tick = (prescaler == PS_W'(PRESCALE - 1));

    // Free-runs only while counting; frozen by pause, restarted by start or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (abort || start) begin
            prescaler <= '0;
        end else if (busy && !pause) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign step   = busy && !pause && tick;
    assign expire = step && !abort && !start && (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Priority: abort, then start, then pause, then the decrement toward expiry.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else if (start) begin
            next_state = pause ? ST_HOLD : ST_RUN;
        end else begin
            case (state)
                ST_RUN, ST_HOLD: begin
                    if (pause) begin
                        next_state = ST_HOLD;
                    end else if (expire) begin
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_RUN;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        case (state)
            ST_RUN, ST_HOLD: busy = 1'b1;
            default:         busy = 1'b0;
        endcase
    end

    // A restart or abort in the terminal cycle discards that expiry, so done stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            done      <= 1'b0;
            phase_q   <= '0;
            freq_q    <= '0;
        end else begin
            done <= expire;
            if (abort) begin
                remaining <= '0;
            end else if (start) begin
                remaining <= load_count;
                phase_q   <= phase;
                freq_q    <= clk_freq;
            end else if (step && (remaining != '0)) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule
